// File: rtl/lagarto_l15_pkg.sv
// Shared types and widths for the Lagarto-to-L15 request path.
// The packed queue entry carries a fixed L15_ADDR_W address; narrower AddrWidth values are zero-extended.
package lagarto_l15_pkg;

   localparam int unsigned L15_RQTYPE_W = 5;
   localparam int unsigned L15_SIZE_W   = 3;
   localparam int unsigned L15_ADDR_W   = 40;
   localparam int unsigned L15_DATA_W   = 64;

   typedef struct packed {
      logic [L15_RQTYPE_W-1:0] rqtype;
      logic                    nc;
      logic [L15_SIZE_W-1:0]   size;
      logic                    threadid;
      logic [L15_ADDR_W-1:0]   address;
      logic [L15_DATA_W-1:0]   data;
   } l15_q_entry_t;

   // Pointer width for a power-of-2 FIFO: index bits plus one wrap bit
   function automatic int unsigned l15_ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/lagarto_l15_fifo.sv
// Depth-entry FIFO of L15 request entries; wrap-bit pointers separate full from empty.
// Head entry is read combinationally from storage; there is no write-to-read bypass.
module lagarto_l15_fifo
   import lagarto_l15_pkg::*;
#(
   parameter int unsigned Depth = 4
) (
   input  logic         clk_i,
   input  logic         reset_l,
   input  logic         push,
   input  logic         pop,
   input  l15_q_entry_t wdata,
   output l15_q_entry_t rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PtrW = l15_ptr_w(Depth);
   localparam int unsigned IdxW = PtrW - 1;

   l15_q_entry_t mem [Depth];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PtrW-1] != rd_ptr[PtrW-1]) &&
                    (wr_ptr[IdxW-1:0] == rd_ptr[IdxW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr[IdxW-1:0]];

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
      end
   end

   // Storage is cleared so head fields read as zero out of reset
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr[IdxW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/lagarto_l15_req_queue.sv
// Request buffer between the Lagarto core and the OpenPiton L1.5 request port, with an outstanding cap.
// Optional perf counters are enabled by defining LAGARTO_L15_REQ_QUEUE_PERF_EN.
module lagarto_l15_req_queue
   import lagarto_l15_pkg::*;
#(
   parameter int unsigned Depth          = 4,
   parameter int unsigned MaxOutstanding = 8,
   parameter int unsigned AddrWidth      = 40
) (
   input  logic                    clk_i,
   input  logic                    reset_l,
   input  logic                    core_req_val_i,
   input  logic [L15_RQTYPE_W-1:0] core_req_rqtype_i,
   input  logic                    core_req_nc_i,
   input  logic [L15_SIZE_W-1:0]   core_req_size_i,
   input  logic                    core_req_threadid_i,
   input  logic [AddrWidth-1:0]    core_req_address_i,
   input  logic [63:0]             core_req_data_i,
   output logic                    core_req_rdy_o,
   output logic                    l15_val_o,
   output logic [L15_RQTYPE_W-1:0] l15_rqtype_o,
   output logic                    l15_nc_o,
   output logic [L15_SIZE_W-1:0]   l15_size_o,
   output logic                    l15_threadid_o,
   output logic [AddrWidth-1:0]    l15_address_o,
   output logic [63:0]             l15_data_o,
   input  logic                    l15_ack_i,
   input  logic                    l15_rtrn_val_i,
   output logic                    idle_o,
   output logic                    err_o
`ifdef LAGARTO_L15_REQ_QUEUE_PERF_EN
   ,
   output logic [31:0]             perf_issued_o,
   output logic [31:0]             perf_full_stall_o,
   output logic [31:0]             perf_cap_stall_o
`endif
);

   localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
   localparam logic [OutW-1:0] OutMax = OutW'(MaxOutstanding);

   l15_q_entry_t    wentry;
   l15_q_entry_t    head;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic            rst_done;
   logic            err_q;
   logic            err_set;
   logic [OutW-1:0] outstanding;
   logic [OutW-1:0] outstanding_nxt;
   logic            at_cap;

   always_comb begin
      wentry          = '0;
      wentry.rqtype   = core_req_rqtype_i;
      wentry.nc       = core_req_nc_i;
      wentry.size     = core_req_size_i;
      wentry.threadid = core_req_threadid_i;
      wentry.address  = L15_ADDR_W'(core_req_address_i);
      wentry.data     = core_req_data_i;
   end

   lagarto_l15_fifo #(
      .Depth (Depth)
   ) u_fifo (
      .clk_i   (clk_i),
      .reset_l (reset_l),
      .push    (push),
      .pop     (pop),
      .wdata   (wentry),
      .rdata   (head),
      .full    (full),
      .empty   (empty)
   );

   // Ready is held low until the first clock after reset release
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) rst_done <= 1'b0;
      else          rst_done <= 1'b1;
   end

   assign at_cap         = (outstanding == OutMax);
   assign core_req_rdy_o = rst_done & ~full;
   assign l15_val_o      = ~empty & (outstanding < OutMax);
   assign push           = core_req_val_i & core_req_rdy_o;
   assign pop            = l15_val_o & l15_ack_i;
   assign idle_o         = empty & (outstanding == '0);
   assign err_o          = err_q;

   assign l15_rqtype_o   = head.rqtype;
   assign l15_nc_o       = head.nc;
   assign l15_size_o     = head.size;
   assign l15_threadid_o = head.threadid;
   assign l15_address_o  = AddrWidth'(head.address);
   assign l15_data_o     = head.data;

   // A return with nothing outstanding is dropped; a same-cycle pop is still counted
   always_comb begin
      outstanding_nxt = outstanding;
      unique case ({pop, l15_rtrn_val_i})
         2'b10:   outstanding_nxt = outstanding + OutW'(1);
         2'b01:   outstanding_nxt = (outstanding == '0) ? '0 : outstanding - OutW'(1);
         2'b11:   outstanding_nxt = (outstanding == '0) ? OutW'(1) : outstanding;
         default: outstanding_nxt = outstanding;
      endcase
   end

   assign err_set = (l15_ack_i & ~l15_val_o) | (l15_rtrn_val_i & (outstanding == '0));

   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         outstanding <= '0;
         err_q       <= 1'b0;
      end else begin
         outstanding <= outstanding_nxt;
         err_q       <= err_q | err_set;
      end
   end

`ifdef LAGARTO_L15_REQ_QUEUE_PERF_EN
   logic [31:0] issued_q;
   logic [31:0] full_stall_q;
   logic [31:0] cap_stall_q;

   // Saturating event counters
   always_ff @(posedge clk_i or negedge reset_l) begin
      if (!reset_l) begin
         issued_q     <= '0;
         full_stall_q <= '0;
         cap_stall_q  <= '0;
      end else begin
         if (pop && issued_q != '1)
            issued_q <= issued_q + 32'd1;
         if (core_req_val_i && !core_req_rdy_o && full_stall_q != '1)
            full_stall_q <= full_stall_q + 32'd1;
         if (!empty && at_cap && cap_stall_q != '1)
            cap_stall_q <= cap_stall_q + 32'd1;
      end
   end

   assign perf_issued_o     = issued_q;
   assign perf_full_stall_o = full_stall_q;
   assign perf_cap_stall_o  = cap_stall_q;
`else
   logic unused_at_cap;
   assign unused_at_cap = at_cap;
`endif

endmodule

// File: tb/tb_lagarto_l15_req_queue.sv
// Directed self-checking bench for lagarto_l15_req_queue (Depth=4, MaxOutstanding=2).
// Perf counter checks are included when LAGARTO_L15_REQ_QUEUE_PERF_EN is defined.
module tb_lagarto_l15_req_queue;

   localparam int unsigned AW = 40;

   logic          clk_i = 1'b0;
   logic          reset_l;
   logic          core_req_val_i;
   logic [4:0]    core_req_rqtype_i;
   logic          core_req_nc_i;
   logic [2:0]    core_req_size_i;
   logic          core_req_threadid_i;
   logic [AW-1:0] core_req_address_i;
   logic [63:0]   core_req_data_i;
   logic          core_req_rdy_o;
   logic          l15_val_o;
   logic [4:0]    l15_rqtype_o;
   logic          l15_nc_o;
   logic [2:0]    l15_size_o;
   logic          l15_threadid_o;
   logic [AW-1:0] l15_address_o;
   logic [63:0]   l15_data_o;
   logic          l15_ack_i;
   logic          l15_rtrn_val_i;
   logic          idle_o;
   logic          err_o;
`ifdef LAGARTO_L15_REQ_QUEUE_PERF_EN
   logic [31:0]   perf_issued_o;
   logic [31:0]   perf_full_stall_o;
   logic [31:0]   perf_cap_stall_o;
`endif

   int checks   = 0;
   int failures = 0;

   lagarto_l15_req_queue #(
      .Depth          (4),
      .MaxOutstanding (2),
      .AddrWidth      (AW)
   ) dut (
      .clk_i               (clk_i),
      .reset_l             (reset_l),
      .core_req_val_i      (core_req_val_i),
      .core_req_rqtype_i   (core_req_rqtype_i),
      .core_req_nc_i       (core_req_nc_i),
      .core_req_size_i     (core_req_size_i),
      .core_req_threadid_i (core_req_threadid_i),
      .core_req_address_i  (core_req_address_i),
      .core_req_data_i     (core_req_data_i),
      .core_req_rdy_o      (core_req_rdy_o),
      .l15_val_o           (l15_val_o),
      .l15_rqtype_o        (l15_rqtype_o),
      .l15_nc_o            (l15_nc_o),
      .l15_size_o          (l15_size_o),
      .l15_threadid_o      (l15_threadid_o),
      .l15_address_o       (l15_address_o),
      .l15_data_o          (l15_data_o),
      .l15_ack_i           (l15_ack_i),
      .l15_rtrn_val_i      (l15_rtrn_val_i),
      .idle_o              (idle_o),
      .err_o               (err_o)
`ifdef LAGARTO_L15_REQ_QUEUE_PERF_EN
      ,
      .perf_issued_o       (perf_issued_o),
      .perf_full_stall_o   (perf_full_stall_o),
      .perf_cap_stall_o    (perf_cap_stall_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic drive_req(input logic [AW-1:0] addr, input logic [4:0] rqtype, input logic [63:0] data);
      core_req_val_i      = 1'b1;
      core_req_rqtype_i   = rqtype;
      core_req_nc_i       = 1'b0;
      core_req_size_i     = 3'd3;
      core_req_threadid_i = 1'b0;
      core_req_address_i  = addr;
      core_req_data_i     = data;
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      core_req_val_i = 1'b0;
      l15_ack_i = 1'b0;
      l15_rtrn_val_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_l = 1'b1;
      tick();
   endtask

   logic [AW-1:0] addr;

   initial begin
      reset_l             = 1'b0;
      core_req_val_i      = 1'b0;
      core_req_rqtype_i   = '0;
      core_req_nc_i       = 1'b0;
      core_req_size_i     = '0;
      core_req_threadid_i = 1'b0;
      core_req_address_i  = '0;
      core_req_data_i     = '0;
      l15_ack_i           = 1'b0;
      l15_rtrn_val_i      = 1'b0;

      // Reset state
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_rdy_low",  64'(core_req_rdy_o), 64'd0);
      check("rst_val_low",  64'(l15_val_o), 64'd0);
      check("rst_idle",     64'(idle_o), 64'd1);
      check("rst_err",      64'(err_o), 64'd0);
      check("rst_addr",     64'(l15_address_o), 64'd0);
      reset_l = 1'b1;
      tick();
      check("post_rst_rdy", 64'(core_req_rdy_o), 64'd1);
      check("post_rst_idle", 64'(idle_o), 64'd1);
      check("post_rst_val", 64'(l15_val_o), 64'd0);

      // Single request: push, issue next cycle, ack two cycles later, return
      drive_req(40'h80_0000_1000, 5'd0, 64'hDEAD_BEEF_0000_0001);
      tick();
      core_req_val_i = 1'b0;
      check("single_val",  64'(l15_val_o), 64'd1);
      check("single_addr", 64'(l15_address_o), 64'h80_0000_1000);
      check("single_data", l15_data_o, 64'hDEAD_BEEF_0000_0001);
      tick();
      check("single_stable", 64'(l15_address_o), 64'h80_0000_1000);
      l15_ack_i = 1'b1;
      tick();
      l15_ack_i = 1'b0;
      check("single_popped_val", 64'(l15_val_o), 64'd0);
      check("single_outst_idle", 64'(idle_o), 64'd0);
      l15_rtrn_val_i = 1'b1;
      tick();
      l15_rtrn_val_i = 1'b0;
      check("single_rtrn_idle", 64'(idle_o), 64'd1);

      // Fill: five back-to-back pushes, only four accepted
      for (int i = 0; i < 5; i++) begin
         drive_req(40'h00_0000_2000 + AW'(i) * 40'h40, 5'(i), 64'(i));
         if (i == 4) check("fill_rdy_full", 64'(core_req_rdy_o), 64'd0);
         tick();
      end
      core_req_val_i = 1'b0;
      // Drain in order; pop with concurrent return keeps outstanding at 1
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fill_order%0d", i), 64'(l15_address_o), 64'h2000 + 64'(i) * 64'h40);
         l15_ack_i = 1'b1;
         l15_rtrn_val_i = (i != 0);
         tick();
      end
      l15_ack_i = 1'b0;
      l15_rtrn_val_i = 1'b0;
      check("fill_empty_val", 64'(l15_val_o), 64'd0);
      check("fill_outst1_idle", 64'(idle_o), 64'd0);
      l15_rtrn_val_i = 1'b1;
      tick();
      l15_rtrn_val_i = 1'b0;
      check("fill_drained_idle", 64'(idle_o), 64'd1);

      // Outstanding cap of 2
      for (int i = 0; i < 3; i++) begin
         drive_req(40'h00_0000_3000 + AW'(i) * 40'h40, 5'd0, 64'd0);
         tick();
      end
      core_req_val_i = 1'b0;
      l15_ack_i = 1'b1;
      tick();
      check("cap_second_val", 64'(l15_val_o), 64'd1);
      tick();
      l15_ack_i = 1'b0;
      check("cap_val_low", 64'(l15_val_o), 64'd0);
      check("cap_head_addr", 64'(l15_address_o), 64'h3080);
      l15_rtrn_val_i = 1'b1;
      tick();
      l15_rtrn_val_i = 1'b0;
      check("cap_reissue_val", 64'(l15_val_o), 64'd1);
      l15_ack_i = 1'b1;
      tick();
      l15_ack_i = 1'b0;
      l15_rtrn_val_i = 1'b1;
      tick();
      tick();
      l15_rtrn_val_i = 1'b0;
      check("cap_drained_idle", 64'(idle_o), 64'd1);

      // Push and pop in the same cycle at occupancy 2
      for (int i = 0; i < 2; i++) begin
         drive_req(40'h00_0000_4000 + AW'(i) * 40'h40, 5'd0, 64'd0);
         tick();
      end
      drive_req(40'h00_0000_4080, 5'd0, 64'd0);
      l15_ack_i = 1'b1;
      tick();
      core_req_val_i = 1'b0;
      check("pushpop_head", 64'(l15_address_o), 64'h4040);
      l15_rtrn_val_i = 1'b1;
      tick();
      check("pushpop_head2", 64'(l15_address_o), 64'h4080);
      check("pushpop_val2", 64'(l15_val_o), 64'd1);
      tick();
      l15_ack_i = 1'b0;
      l15_rtrn_val_i = 1'b0;
      check("pushpop_empty", 64'(l15_val_o), 64'd0);
      check("pushpop_outst1", 64'(idle_o), 64'd0);
      l15_rtrn_val_i = 1'b1;
      tick();
      l15_rtrn_val_i = 1'b0;
      check("pushpop_idle", 64'(idle_o), 64'd1);
      check("no_err_so_far", 64'(err_o), 64'd0);

      // Return with nothing outstanding
      l15_rtrn_val_i = 1'b1;
      tick();
      l15_rtrn_val_i = 1'b0;
      check("rtrn_err_set", 64'(err_o), 64'd1);
      check("rtrn_err_idle", 64'(idle_o), 64'd1);
      tick();
      tick();
      check("rtrn_err_sticky", 64'(err_o), 64'd1);

      // Reset with a request queued, then ack with nothing valid
      drive_req(40'h00_0000_5000, 5'd0, 64'd0);
      tick();
      do_reset();
      check("rerst_err_clear", 64'(err_o), 64'd0);
      check("rerst_idle", 64'(idle_o), 64'd1);
      l15_ack_i = 1'b1;
      tick();
      l15_ack_i = 1'b0;
      check("ack_err_set", 64'(err_o), 64'd1);

`ifdef LAGARTO_L15_REQ_QUEUE_PERF_EN
      // Ten cycles of push attempts against a full queue
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_req(40'h00_0000_6000 + AW'(i) * 40'h40, 5'd0, 64'd0);
         tick();
      end
      for (int i = 0; i < 10; i++) tick();
      core_req_val_i = 1'b0;
      check("perf_full_stall", 64'(perf_full_stall_o), 64'd10);
      l15_ack_i = 1'b1;
      tick();
      tick();
      l15_ack_i = 1'b0;
      check("perf_issued", 64'(perf_issued_o), 64'd2);
      tick();
      check("perf_cap_stall", 64'(perf_cap_stall_o), 64'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lagarto_l15_req_queue.md
Name: lagarto_l15_req_queue

Overview:
Request buffer between the Lagarto core's L1.5 request output and the OpenPiton L1.5 (L15) request port, inside the meep_vas tile.
- Decouples core issue from L15 acceptance with a small FIFO.
- Enforces a cap on outstanding transactions by counting return packets.
- Reports idle for fence/drain logic.

Parameters:
- Depth, 4, FIFO entries; power of 2, minimum 2.
- MaxOutstanding, 8, maximum requests issued to L15 and not yet returned; minimum 1.
- AddrWidth, 40, physical address width of a request.

Ports:
- clk_i  in  1  clock.
- reset_l  in  1  asynchronous active-low reset.
- core_req_val_i  in  1  core request valid.
- core_req_rqtype_i  in  5  L15 request type.
- core_req_nc_i  in  1  non-cacheable.
- core_req_size_i  in  3  access size.
- core_req_threadid_i  in  1  thread id.
- core_req_address_i  in  AddrWidth  physical address.
- core_req_data_i  in  64  store data.
- core_req_rdy_o  out  1  queue can accept this cycle.
- l15_val_o  out  1  head request valid toward L15.
- l15_rqtype_o  out  5  head field.
- l15_nc_o  out  1  head field.
- l15_size_o  out  3  head field.
- l15_threadid_o  out  1  head field.
- l15_address_o  out  AddrWidth  head field.
- l15_data_o  out  64  head field.
- l15_ack_i  in  1  L15 accepted the head request.
- l15_rtrn_val_i  in  1  one-cycle pulse, one return packet from L15.
- idle_o  out  1  FIFO empty and zero outstanding.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (async, reset_l low):
  - Pointers and counters = 0.
  - l15_val_o = 0, core_req_rdy_o = 0 while reset_l is low; core_req_rdy_o = 1 from the first clock after release.
  - idle_o = 1, err_o = 0; data outputs = 0.
- Storage:
  - FIFO of Depth entries holding all request fields.
  - Read/write pointers are log2(Depth)+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2*Depth.
- core_req_rdy_o = !full, combinational from state only (no dependence on core_req_val_i).
- Push occurs when core_req_val_i & core_req_rdy_o. Push when full is ignored and is not an error.
- No bypass: a request pushed into an empty queue at cycle N drives l15_val_o at N+1.
- Head issue:
  - l15_val_o = !empty & (outstanding < MaxOutstanding).
  - Head fields are driven from the FIFO head whenever the FIFO is non-empty, and are stable while l15_val_o is high.
- Pop occurs when l15_val_o & l15_ack_i. On pop, outstanding increments.
- l15_ack_i while l15_val_o = 0 is ignored and sets err_o.
- Return on l15_rtrn_val_i:
  - outstanding decrements.
  - If outstanding is already 0, it stays 0 and err_o is set.
- Pop and return in the same cycle: outstanding unchanged.
- Push and pop in the same cycle: occupancy unchanged. Allowed at any occupancy except that push is blocked when full, even if a pop occurs that cycle.
- At outstanding == MaxOutstanding, l15_val_o drops. It re-asserts the cycle after a return decrements the count.
- idle_o = empty & (outstanding == 0), combinational.
- err_o is sticky until reset.
- Reset mid-transaction: all queued and outstanding state is discarded immediately. Upstream and downstream are reset together with this block.

Optional Feature:
- Macro: LAGARTO_L15_REQ_QUEUE_PERF_EN.
- When defined, adds three outputs:
  - perf_issued_o [31:0]: counts pops.
  - perf_full_stall_o [31:0]: counts cycles with core_req_val_i & !core_req_rdy_o.
  - perf_cap_stall_o [31:0]: counts cycles with !empty & outstanding == MaxOutstanding.
- All three counters saturate at all-ones and reset to 0.
- When not defined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package lagarto_l15_pkg holds:
  - L15_RQTYPE_W = 5, L15_SIZE_W = 3.
  - Packed struct l15_q_entry_t holding rqtype, nc, size, threadid, address, data.
  - Localparam function for pointer width.
- One natural sub-module: lagarto_l15_fifo, a generic Depth-entry FIFO of l15_q_entry_t with push/pop/full/empty. The outstanding counter, issue gating, error and perf logic stay in the top.

Test Plan:
- Reset with Depth=4: core_req_rdy_o = 0 while reset_l is low; after release, idle_o = 1, core_req_rdy_o = 1, l15_val_o = 0, err_o = 0.
- Single request: push address 0x80_0000_1000, rqtype 0 at cycle N → l15_val_o = 1 at N+1 with address 0x80_0000_1000. Ack at N+3 → outstanding = 1, idle_o = 0. rtrn pulse → idle_o = 1.
- Fill queue: 5 back-to-back pushes with l15_ack_i held low → 4 accepted, core_req_rdy_o = 0 on the 5th. Ack each head → addresses emerge in FIFO order.
- Outstanding cap, MaxOutstanding=2: issue 3 requests with no returns → l15_val_o low after 2 pops. One rtrn pulse → 3rd request issued the next cycle.
- Simultaneous events: pop and rtrn in the same cycle with outstanding=1 → stays 1. Push and pop in the same cycle at occupancy 2 → stays 2.
- Errors: rtrn pulse with outstanding=0 → err_o = 1 and held, counter stays 0. With the perf macro defined, a 10-cycle full stall → perf_full_stall_o = 10.
